// File: rtl/flash_pkg.sv
// Shared encodings for the flash command sequencer: SPI opcodes, op/request
// type codes, sequencer states and the op descriptor handed to spi_drive.
package flash_pkg;

  localparam int unsigned OP_ADDR_W = 24;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  localparam logic [2:0] OPT_CMD   = 3'd0;
  localparam logic [2:0] OPT_READ  = 3'd1;
  localparam logic [2:0] OPT_WRITE = 3'd2;

  localparam logic [1:0] REQ_READ = 2'd0;
  localparam logic [1:0] REQ_PP   = 2'd1;
  localparam logic [1:0] REQ_SE   = 2'd2;
  localparam logic [1:0] REQ_BAD  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WREN,
    ST_WREN_WAIT,
    ST_GAP,
    ST_MAIN,
    ST_MAIN_WAIT,
    ST_POLL,
    ST_POLL_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  len;
    logic [2:0]  typ;
    logic [15:0] clk_len;
  } spi_op_t;

  // Build one op descriptor; nbytes is the data phase length in bytes.
  function automatic spi_op_t mk_op(input logic [7:0] opc,
                                    input logic [OP_ADDR_W-1:0] addr,
                                    input logic [2:0] typ,
                                    input logic with_addr,
                                    input logic [8:0] nbytes);
    spi_op_t op;
    logic [15:0] hdr;
    hdr        = with_addr ? 16'd32 : 16'd8;
    op.data    = {opc, (with_addr ? addr : 24'd0)};
    op.len     = with_addr ? 8'd32 : 8'd8;
    op.typ     = typ;
    op.clk_len = hdr + {4'd0, nbytes, 3'd0};
    return op;
  endfunction

endpackage

// File: rtl/flash_ctrl.sv
// Flash command sequencer: turns one read / page-program / sector-erase request
// into the WREN, main op and RDSR poll series on spi_drive's op port.
module flash_ctrl
  import flash_pkg::*;
#(
  parameter int unsigned P_ADDR_W   = 24,
  parameter int unsigned P_GAP_CYC  = 4,
  parameter int unsigned P_POLL_MAX = 65535
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [1:0]          i_req_type,
  input  logic [P_ADDR_W-1:0] i_req_addr,
  input  logic [8:0]          i_req_len,
  input  logic [7:0]          i_wr_data,
  output logic                o_wr_req,
  output logic [7:0]          o_rd_data,
  output logic                o_rd_valid,
  output logic                o_rd_last,
  output logic                o_done,
  output logic                o_err,
  output logic [31:0]         o_op_data,
  output logic [7:0]          o_op_len,
  output logic [2:0]          o_op_type,
  output logic [15:0]         o_clk_len,
  output logic                o_op_valid,
  input  logic                i_op_ready,
  output logic [7:0]          o_spi_wr_data,
  input  logic                i_spi_wr_req,
  input  logic [7:0]          i_spi_rd_data,
  input  logic                i_spi_rd_valid
);

  localparam int unsigned LEN_W  = 9;
  localparam int unsigned GAP_W  = (P_GAP_CYC > 1) ? $clog2(P_GAP_CYC) : 1;
  localparam int unsigned POLL_W = $clog2(P_POLL_MAX + 2);

  localparam spi_op_t WREN_OP = mk_op(OPC_WREN, 24'd0, OPT_CMD, 1'b0, 9'd0);
  localparam spi_op_t RDSR_OP = mk_op(OPC_RDSR, 24'd0, OPT_READ, 1'b0, 9'd1);

  state_t              state;
  state_t              gap_next;
  spi_op_t             op_q;
  logic [1:0]          req_type_q;
  logic [P_ADDR_W-1:0] req_addr_q;
  logic [LEN_W-1:0]    req_len_q;
  logic [LEN_W-1:0]    rd_cnt;
  logic [LEN_W-1:0]    wr_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [POLL_W-1:0]   poll_cnt;
  logic                wip_q;
  logic                rdy_q;

  logic                op_done_c;
  logic                bad_c;
  logic                wip_c;
  logic [POLL_W-1:0]   poll_nxt_c;
  spi_op_t             read_op_c;
  spi_op_t             main_op_c;
  spi_op_t             gap_op_c;

  assign o_op_data     = op_q.data;
  assign o_op_len      = op_q.len;
  assign o_op_type     = op_q.typ;
  assign o_clk_len     = op_q.clk_len;
  assign o_spi_wr_data = i_wr_data;

  // Program byte requests pass through only during the PP data phase, up to len.
  assign o_wr_req = i_spi_wr_req && (state == ST_MAIN_WAIT) &&
                    (req_type_q == REQ_PP) && (wr_cnt < req_len_q);

  assign op_done_c  = i_op_ready && !rdy_q;
  assign wip_c      = i_spi_rd_valid ? i_spi_rd_data[0] : wip_q;
  assign poll_nxt_c = poll_cnt + POLL_W'(1);
  assign bad_c      = (i_req_type == REQ_BAD) ||
                      ((i_req_type != REQ_SE) && ((i_req_len == 9'd0) || (i_req_len > 9'd256)));
  assign read_op_c  = mk_op(OPC_READ, 24'(i_req_addr), OPT_READ, 1'b1, i_req_len);

  // Main op of the latched request, and the op launched when a gap expires.
  always_comb begin
    main_op_c = mk_op(OPC_SE, 24'(req_addr_q), OPT_CMD, 1'b1, 9'd0);
    case (req_type_q)
      REQ_READ: main_op_c = mk_op(OPC_READ, 24'(req_addr_q), OPT_READ, 1'b1, req_len_q);
      REQ_PP:   main_op_c = mk_op(OPC_PP, 24'(req_addr_q), OPT_WRITE, 1'b1, req_len_q);
      default:  main_op_c = mk_op(OPC_SE, 24'(req_addr_q), OPT_CMD, 1'b1, 9'd0);
    endcase
    gap_op_c = (gap_next == ST_MAIN) ? main_op_c : RDSR_OP;
  end

  // Sequencer state, request latches, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      gap_next    <= ST_IDLE;
      op_q        <= '0;
      req_type_q  <= '0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      gap_cnt     <= '0;
      poll_cnt    <= '0;
      wip_q       <= 1'b0;
      rdy_q       <= 1'b0;
      o_req_ready <= 1'b1;
      o_op_valid  <= 1'b0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_rd_last   <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      rdy_q      <= i_op_ready;
      o_rd_valid <= 1'b0;
      o_rd_last  <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      if (o_wr_req) wr_cnt <= wr_cnt + LEN_W'(1);
      case (state)
        ST_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            req_type_q  <= i_req_type;
            req_addr_q  <= i_req_addr;
            req_len_q   <= i_req_len;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            poll_cnt    <= '0;
            o_req_ready <= 1'b0;
            if (bad_c) begin
              o_done <= 1'b1;
              o_err  <= 1'b1;
              state  <= ST_DONE;
            end else if (i_req_type == REQ_READ) begin
              op_q       <= read_op_c;
              o_op_valid <= 1'b1;
              state      <= ST_MAIN;
            end else begin
              op_q       <= WREN_OP;
              o_op_valid <= 1'b1;
              state      <= ST_WREN;
            end
          end
        end
        ST_WREN: if (i_op_ready) begin o_op_valid <= 1'b0; state <= ST_WREN_WAIT; end
        ST_MAIN: if (i_op_ready) begin o_op_valid <= 1'b0; state <= ST_MAIN_WAIT; end
        ST_POLL: if (i_op_ready) begin o_op_valid <= 1'b0; state <= ST_POLL_WAIT; end
        ST_WREN_WAIT: begin
          if (op_done_c) begin
            gap_cnt  <= '0;
            gap_next <= ST_MAIN;
            state    <= ST_GAP;
          end
        end
        ST_MAIN_WAIT: begin
          if ((req_type_q == REQ_READ) && i_spi_rd_valid && (rd_cnt < req_len_q)) begin
            o_rd_valid <= 1'b1;
            o_rd_data  <= i_spi_rd_data;
            o_rd_last  <= (rd_cnt == req_len_q - LEN_W'(1));
            rd_cnt     <= rd_cnt + LEN_W'(1);
          end
          if (op_done_c) begin
            if (req_type_q == REQ_READ) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              gap_cnt  <= '0;
              gap_next <= ST_POLL;
              state    <= ST_GAP;
            end
          end
        end
        ST_POLL_WAIT: begin
          if (i_spi_rd_valid) wip_q <= i_spi_rd_data[0];
          if (op_done_c) begin
            poll_cnt <= poll_nxt_c;
            if (!wip_c) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else if (poll_nxt_c > POLL_W'(P_POLL_MAX)) begin
              o_done <= 1'b1;
              o_err  <= 1'b1;
              state  <= ST_DONE;
            end else begin
              gap_cnt  <= '0;
              gap_next <= ST_POLL;
              state    <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(P_GAP_CYC - 1)) begin
            op_q       <= gap_op_c;
            o_op_valid <= 1'b1;
            state      <= gap_next;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          o_req_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_ctrl.sv
// Bench for flash_ctrl: behavioural spi_drive + flash model, request-level
// reference model feeding a scoreboard, monitors comparing every DUT output.
module tb_flash_ctrl;
  import flash_pkg::*;

  localparam int unsigned GAP  = 4;
  localparam int unsigned PMAX = 3;

  logic        i_clk, i_rst;
  logic        i_req_valid, o_req_ready;
  logic [1:0]  i_req_type;
  logic [23:0] i_req_addr;
  logic [8:0]  i_req_len;
  logic [7:0]  i_wr_data;
  logic        o_wr_req;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid, o_rd_last, o_done, o_err;
  logic [31:0] o_op_data;
  logic [7:0]  o_op_len;
  logic [2:0]  o_op_type;
  logic [15:0] o_clk_len;
  logic        o_op_valid, i_op_ready;
  logic [7:0]  o_spi_wr_data;
  logic        i_spi_wr_req;
  logic [7:0]  i_spi_rd_data;
  logic        i_spi_rd_valid;

  flash_ctrl #(.P_ADDR_W(24), .P_GAP_CYC(GAP), .P_POLL_MAX(PMAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_type(i_req_type), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_wr_data(i_wr_data), .o_wr_req(o_wr_req),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last),
    .o_done(o_done), .o_err(o_err),
    .o_op_data(o_op_data), .o_op_len(o_op_len), .o_op_type(o_op_type),
    .o_clk_len(o_clk_len), .o_op_valid(o_op_valid), .i_op_ready(i_op_ready),
    .o_spi_wr_data(o_spi_wr_data), .i_spi_wr_req(i_spi_wr_req),
    .i_spi_rd_data(i_spi_rd_data), .i_spi_rd_valid(i_spi_rd_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  len;
    logic [2:0]  typ;
    logic [15:0] clk;
    logic        gap;
  } eop_t;
  typedef struct packed { logic err; logic bad; } edone_t;

  eop_t       op_q[$];
  logic [8:0] rd_q[$];
  logic [7:0] wr_q[$];
  edone_t     done_q[$];
  logic [7:0] usr_q[$];
  logic [7:0] pp_fix[$];

  logic [7:0] fl_mem[int];
  logic [7:0] ref_mem[int];

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, acc_cyc = 0, rdy_rise_cyc = 0;
  int cfg_busy = 0, busy_left = 0;
  bit wel = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [7:0] init_b(input int a);
    return 8'(a * 37 + (a >>> 8) + 1);
  endfunction
  function automatic logic [7:0] fl_rd(input int a);
    return fl_mem.exists(a) ? fl_mem[a] : init_b(a);
  endfunction
  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_b(a);
  endfunction
  function automatic int page_addr(input logic [23:0] a, input int i);
    return int'({a[23:8], 8'(a[7:0] + 8'(i))});
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Expected op as seen on the spi_drive port, from the opcode table.
  function automatic void exp_op(input logic [7:0] opc, input logic [23:0] a,
                                 input bit has_addr, input logic [2:0] typ,
                                 input int nbytes, input bit gap);
    eop_t e;
    int hdr;
    hdr    = has_addr ? 32 : 8;
    e.data = has_addr ? {opc, a} : {opc, 24'h0};
    e.len  = 8'(hdr);
    e.typ  = typ;
    e.clk  = 16'(hdr + 8 * nbytes);
    e.gap  = gap;
    op_q.push_back(e);
  endfunction

  // Behavioural spi_drive + flash: executes each accepted op.
  task automatic send_byte(input logic [7:0] b);
    repeat (2) tick;
    i_spi_rd_valid = 1'b1;
    i_spi_rd_data  = b;
    tick;
    i_spi_rd_valid = 1'b0;
  endtask

  initial begin : spi_model
    logic [31:0] d;
    logic [7:0]  l, opc, b;
    logic [15:0] c;
    logic [23:0] a;
    int nb;
    i_op_ready = 1'b1; i_spi_rd_valid = 1'b0; i_spi_rd_data = '0; i_spi_wr_req = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst && o_op_valid && i_op_ready) begin
        d = o_op_data; l = o_op_len; c = o_clk_len;
        nb  = (int'(c) - int'(l)) / 8;
        opc = d[31:24];
        a   = d[23:0];
        tick;
        i_op_ready = 1'b0;
        case (opc)
          8'h06: wel = 1'b1;
          8'h03: for (int i = 0; i < nb; i++) send_byte(fl_rd(int'(a) + i));
          8'h05: for (int i = 0; i < nb; i++) begin
            send_byte({6'd0, wel, (busy_left > 0)});
            if (busy_left > 0) busy_left--;
          end
          8'h02: begin
            for (int i = 0; i < nb; i++) begin
              tick;
              i_spi_wr_req = 1'b1;
              @(negedge i_clk);
              b = o_spi_wr_data;
              tick;
              i_spi_wr_req = 1'b0;
              fl_mem[page_addr(a, i)] = b;
            end
            busy_left = cfg_busy;
            wel = 1'b0;
          end
          8'h20: begin
            for (int k = 0; k < 4096; k++) fl_mem[(int'(a) & ~32'hFFF) + k] = 8'hFF;
            busy_left = cfg_busy;
            wel = 1'b0;
          end
          default: ;
        endcase
        repeat (2) tick;
        i_op_ready   = 1'b1;
        rdy_rise_cyc = cyc;
      end
    end
  end

  // User write-data source: presents the next queued program byte.
  initial begin : usr_src
    bit t;
    i_wr_data = '0;
    forever begin
      @(negedge i_clk);
      t = o_wr_req;
      tick;
      if (t && usr_q.size() > 0) void'(usr_q.pop_front());
      i_wr_data = (usr_q.size() > 0) ? usr_q[0] : 8'h00;
    end
  end

  // Monitor: compares every DUT output event against the scoreboard queues.
  initial begin : monitor
    eop_t e;
    edone_t dn;
    logic [8:0] r;
    logic [7:0] w;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        if (o_op_valid && i_op_ready) begin
          if (op_q.size() == 0) fail_now($sformatf("unexpected_op data=%h", o_op_data));
          else begin
            e = op_q.pop_front();
            chk("op", 64'({o_op_data, o_op_len, o_op_type, o_clk_len}),
                64'({e.data, e.len, e.typ, e.clk}));
            if (e.gap) chk("gap", 64'(cyc - rdy_rise_cyc), 64'(GAP + 1));
          end
        end
        if (o_rd_valid) begin
          if (rd_q.size() == 0) fail_now("unexpected_rd");
          else begin
            r = rd_q.pop_front();
            chk("rd_byte", 64'({o_rd_last, o_rd_data}), 64'(r));
          end
        end
        if (o_wr_req) begin
          if (wr_q.size() == 0) fail_now("unexpected_wr_req");
          else begin
            w = wr_q.pop_front();
            chk("wr_data", 64'(o_spi_wr_data), 64'(w));
          end
        end
        if (o_err && !o_done) fail_now("err_without_done");
        if (o_done) begin
          if (done_q.size() == 0) fail_now("unexpected_done");
          else begin
            dn = done_q.pop_front();
            chk("done_err", 64'(o_err), 64'(dn.err));
            if (dn.bad) chk("bad_latency", 64'(cyc - acc_cyc), 64'd1);
          end
          done_cnt++;
        end
      end
    end
  end

  // Reference model: expected ops/bytes/done for one request, then issue it.
  task automatic send_req(input logic [1:0] t, input logic [23:0] a,
                          input logic [8:0] l, input int busy);
    bit bad;
    int np, k, start;
    logic [7:0] b;
    bad = (t == 2'd3) || ((t != 2'd2) && ((l == 9'd0) || (l > 9'd256)));
    cfg_busy = busy;
    np = (busy > int'(PMAX)) ? int'(PMAX) + 1 : busy + 1;
    if (bad) done_q.push_back('{err: 1'b1, bad: 1'b1});
    else if (t == 2'd0) begin
      exp_op(8'h03, a, 1, 3'd1, int'(l), 0);
      for (int i = 0; i < int'(l); i++)
        rd_q.push_back({(i == int'(l) - 1), ref_rd(int'(a) + i)});
      done_q.push_back('{err: 1'b0, bad: 1'b0});
    end else begin
      exp_op(8'h06, 24'h0, 0, 3'd0, 0, 0);
      if (t == 2'd1) begin
        exp_op(8'h02, a, 1, 3'd2, int'(l), 1);
        for (int i = 0; i < int'(l); i++) begin
          b = (pp_fix.size() > 0) ? pp_fix.pop_front() : 8'($urandom);
          usr_q.push_back(b);
          wr_q.push_back(b);
          ref_mem[page_addr(a, i)] = b;
        end
      end else begin
        exp_op(8'h20, a, 1, 3'd0, 0, 1);
        for (int j = 0; j < 4096; j++) ref_mem[(int'(a) & ~32'hFFF) + j] = 8'hFF;
      end
      for (int i = 0; i < np; i++) exp_op(8'h05, 24'h0, 0, 3'd1, 1, 1);
      done_q.push_back('{err: (busy > int'(PMAX)), bad: 1'b0});
    end
    tick;
    i_req_valid = 1'b1; i_req_type = t; i_req_addr = a; i_req_len = l;
    k = 0;
    do begin @(negedge i_clk); k++; end while (!o_req_ready && k < 50);
    if (!o_req_ready) fail_now("ready_timeout");
    acc_cyc = cyc;
    start = done_cnt;
    tick;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    chk("ready_drop", 64'(o_req_ready), 64'd0);
    k = 0;
    while (done_cnt == start && k < 3000) begin @(posedge i_clk); k++; end
    if (done_cnt == start) fail_now("done_timeout");
    chk("left_ops", 64'(op_q.size() + rd_q.size() + wr_q.size()), 64'd0);
  endtask

  task automatic flush_all;
    op_q.delete(); rd_q.delete(); wr_q.delete(); done_q.delete(); usr_q.delete();
  endtask

  // Async reset in the gap after WREN of a page program.
  task automatic reset_mid_pp;
    int k;
    cfg_busy = 1;
    exp_op(8'h06, 24'h0, 0, 3'd0, 0, 0);
    tick;
    i_req_valid = 1'b1; i_req_type = 2'd1; i_req_addr = 24'h002000; i_req_len = 9'd2;
    tick;
    i_req_valid = 1'b0;
    k = 0;
    while (op_q.size() != 0 && k < 200) begin tick; k++; end
    repeat (2) tick;
    while (!i_op_ready && k < 400) begin tick; k++; end
    if (!i_op_ready) fail_now("wren_timeout");
    repeat (2) tick;
    #2 i_rst = 1'b0;
    #1;
    chk("rst_ready", 64'(o_req_ready), 64'd1);
    chk("rst_outs", 64'({o_op_valid, o_done, o_err, o_rd_valid, o_rd_last, o_wr_req, o_rd_data}), 64'd0);
    chk("rst_op", 64'({o_op_data, o_op_len, o_op_type, o_clk_len}), 64'd0);
    flush_all();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r;
    logic [23:0] a;
    logic [8:0] l;
    i_rst = 1'b0; i_req_valid = 1'b0; i_req_type = '0; i_req_addr = '0; i_req_len = '0;
    fl_mem[32'h1000] = 8'h11; fl_mem[32'h1001] = 8'h22;
    fl_mem[32'h1002] = 8'h33; fl_mem[32'h1003] = 8'h44;
    ref_mem = fl_mem;
    repeat (3) @(negedge i_clk);
    chk("reset_ready", 64'(o_req_ready), 64'd1);
    chk("reset_outs", 64'({o_op_valid, o_done, o_err, o_rd_valid, o_rd_last, o_wr_req, o_rd_data}), 64'd0);
    chk("reset_op", 64'({o_op_data, o_op_len, o_op_type, o_clk_len}), 64'd0);
    i_rst = 1'b1;

    send_req(2'd0, 24'h001000, 9'd4, 0);
    pp_fix.push_back(8'hA5); pp_fix.push_back(8'h5A);
    send_req(2'd1, 24'h000200, 9'd2, 3);
    send_req(2'd0, 24'h000200, 9'd2, 0);
    send_req(2'd2, 24'h003000, 9'd0, 2);
    send_req(2'd0, 24'h003010, 9'd3, 0);
    send_req(2'd0, 24'h000100, 9'd0, 0);
    send_req(2'd1, 24'h000100, 9'd257, 0);
    send_req(2'd3, 24'h000100, 9'd4, 0);
    send_req(2'd1, 24'h0002F0, 9'd20, 100);
    send_req(2'd0, 24'h000200, 9'd256, 0);
    send_req(2'd0, 24'h000500, 9'd1, 0);
    reset_mid_pp();
    send_req(2'd0, 24'h001000, 9'd4, 0);

    for (int n = 0; n < 25; n++) begin
      r = int'($urandom_range(0, 9));
      a = 24'($urandom_range(0, 32'h3FFF));
      l = 9'($urandom_range(1, 24));
      if (r <= 3) send_req(2'd0, a, l, 0);
      else if (r <= 6) send_req(2'd1, a, l, int'($urandom_range(0, 5)));
      else if (r <= 8) send_req(2'd2, a, l, int'($urandom_range(0, 3)));
      else begin
        case ($urandom_range(0, 2))
          0: send_req(2'd0, a, 9'd0, 0);
          1: send_req(2'd1, a, 9'($urandom_range(257, 511)), 0);
          default: send_req(2'd3, a, l, 0);
        endcase
      end
    end

    repeat (5) @(negedge i_clk);
    chk("final_queues", 64'(op_q.size() + rd_q.size() + wr_q.size() + done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
